prog_counter_stk: RTL

- Parametrised next-generation RAT program counter with an integrated hardware return-address stack (LIFO).
- CALL/RETURN and interrupt entry no longer need scratch-RAM traffic for the return address.
- Sits between the control unit (load/inc/call/ret strobes) and the program ROM address input.
- Adds configurable address width, stack depth, interrupt and reset vectors, plus stack status and error reporting.

---
 rtl/pc_pkg.sv | 16 +
 rtl/ret_stack.sv | 81 ++++++++
 rtl/prog_counter_stk.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program counter with return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_IMMED = 2'b00,
    SEL_STACK = 2'b01,
    SEL_INTR  = 2'b10,
    SEL_RST   = 2'b11
  } pc_sel_t;

  localparam int          DEF_ADDR_W      = 10;
  localparam int          DEF_STACK_DEPTH = 16;
  localparam logic [9:0]  DEF_INTR_VEC    = 10'h3FF;
  localparam logic [9:0]  DEF_RST_VEC     = 10'h000;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO: synchronous push, combinational top read,
// occupancy count with full/empty decode and overflow/underflow pulses.
module ret_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 16,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              wr_en_s;
  logic              rd_en_s;

  assign full_s  = (cnt_r == CNT_W'(STACK_DEPTH));
  assign empty_s = (cnt_r == {CNT_W{1'b0}});
  assign wr_en_s = push & ~pop & ~full_s & ~rst;
  assign rd_en_s = pop & ~push & ~empty_s;

  // Next occupancy: one push or one pop per cycle, saturating at both ends.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (wr_en_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else if (rd_en_s) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Entry storage; contents are intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[cnt_r[IDX_W-1:0]] <= push_data;
    end
  end

  // Top-of-stack index; low bits of a full count wrap to the last entry.
  always_comb begin
    top_idx_s = {IDX_W{1'b0}};
    if (!empty_s) begin
      top_idx_s = cnt_r[IDX_W-1:0] - IDX_W'(1);
    end else begin
      top_idx_s = {IDX_W{1'b0}};
    end
  end

  assign top       = mem_r[top_idx_s];
  assign count     = cnt_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = push & ~pop & full_s;
  assign underflow = pop & ~push & empty_s;

endmodule

// File: rtl/prog_counter_stk.sv
// Program counter with load mux, RST > LD > INC > hold priority, integrated
// return-address stack and a sticky stack-error flag.
module prog_counter_stk
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] INTR_VEC    = ADDR_W'(DEF_INTR_VEC),
  parameter logic [ADDR_W-1:0] RST_VEC     = ADDR_W'(DEF_RST_VEC)
) (
  input  logic                               clk,
  input  logic                               RST,
  input  logic                               PC_LD,
  input  logic                               PC_INC,
  input  logic [1:0]                         PC_MUX_SEL,
  input  logic [ADDR_W-1:0]                  FROM_IMMED,
  input  logic                               PC_CALL,
  input  logic                               PC_RET,
  output logic [ADDR_W-1:0]                  PC_COUNT,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   STK_CNT,
  output logic                               STK_FULL,
  output logic                               STK_EMPTY,
  output logic                               STK_ERR
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] mux_s;
  logic [ADDR_W-1:0] stk_top_s;
  logic [CNT_W-1:0]  stk_cnt_s;
  logic              stk_full_s;
  logic              stk_empty_s;
  logic              stk_ovf_s;
  logic              stk_unf_s;
  logic              call_s;
  logic              ret_s;
  logic              illegal_s;
  logic              err_r;
  logic              err_nxt_s;
  pc_sel_t           sel_s;

  assign sel_s     = pc_sel_t'(PC_MUX_SEL);
  assign pc_inc_s  = pc_r + ADDR_W'(1);
  assign call_s    = PC_LD & PC_CALL & ~PC_RET;
  assign ret_s     = PC_LD & PC_RET & ~PC_CALL;
  assign illegal_s = PC_LD & PC_CALL & PC_RET;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (RST),
    .push      (call_s),
    .pop       (ret_s),
    .push_data (pc_inc_s),
    .top       (stk_top_s),
    .count     (stk_cnt_s),
    .full      (stk_full_s),
    .empty     (stk_empty_s),
    .overflow  (stk_ovf_s),
    .underflow (stk_unf_s)
  );

  // Load-source mux; the stack source sees the pre-edge top entry.
  always_comb begin
    mux_s = RST_VEC;
    case (sel_s)
      SEL_IMMED: mux_s = FROM_IMMED;
      SEL_STACK: mux_s = stk_top_s;
      SEL_INTR:  mux_s = INTR_VEC;
      SEL_RST:   mux_s = RST_VEC;
      default:   mux_s = RST_VEC;
    endcase
  end

  // Next PC by priority; a return from an empty stack recovers to the reset vector.
  always_comb begin
    pc_nxt_s = pc_r;
    if (PC_LD) begin
      if (ret_s && stk_empty_s) begin
        pc_nxt_s = RST_VEC;
      end else begin
        pc_nxt_s = mux_s;
      end
    end else if (PC_INC) begin
      pc_nxt_s = pc_inc_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  assign err_nxt_s = err_r | stk_ovf_s | stk_unf_s | illegal_s;

  // PC and sticky error registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      pc_r  <= RST_VEC;
      err_r <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  assign PC_COUNT  = pc_r;
  assign STK_CNT   = stk_cnt_s;
  assign STK_FULL  = stk_full_s;
  assign STK_EMPTY = stk_empty_s;
  assign STK_ERR   = err_r;

endmodule
